// File: rtl/addsub_seq_pkg.sv
// Shared ALU definitions: operation codes, default width, sequencer state
// encoding and the comparator ALUFun[3:1] codes that consume our flags.
package alu_defs;

  localparam int WIDTH_DEF = 32;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Comparator ALUFun[3:1]; LT is resolved as Overflow ^ Negative.
  localparam logic [2:0] CMP_NEQ = 3'b000;
  localparam logic [2:0] CMP_EQ  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b010;
  localparam logic [2:0] CMP_LTZ = 3'b101;
  localparam logic [2:0] CMP_LEZ = 3'b110;
  localparam logic [2:0] CMP_GTZ = 3'b111;

endpackage

// File: rtl/addsub_seq_if.sv
// Request/result bundle between the EX stage (master) and the
// slice-serial add/sub unit (slave).
interface addsub_seq_if
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ALUFun0;
  logic             Sign;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] S;
  logic             Zero;
  logic             Overflow;
  logic             Negative;

  modport master (
    output Start, A, B, ALUFun0, Sign,
    input  Busy, Done, S, Zero, Overflow, Negative
  );

  modport slave (
    input  Start, A, B, ALUFun0, Sign,
    output Busy, Done, S, Zero, Overflow, Negative
  );
endinterface

// File: rtl/addsub_seq_slice.sv
// Combinational SLICE_W-bit adder; also exposes the carry into the slice
// MSB so the top slice can produce signed overflow.
module addsub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               cmsb
);
  logic [SLICE_W-1:0] lo;

  assign lo   = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]}
              + {{(SLICE_W-1){1'b0}}, cin};
  assign cmsb = lo[SLICE_W-1];
  assign sum  = {a[SLICE_W-1] ^ b[SLICE_W-1] ^ cmsb, lo[SLICE_W-2:0]};
  assign cout = (a[SLICE_W-1] & b[SLICE_W-1]) | (cmsb & (a[SLICE_W-1] ^ b[SLICE_W-1]));
endmodule

// File: rtl/addsub_seq.sv
// Slice-serial ADD/SUB: one SLICE_W slice per clock, LSB first, with a
// Start/Busy/Done handshake and registered result/flags.
module addsub_seq
  import alu_defs::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SLICE_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  addsub_seq_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d, sign_q, sign_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout, slice_cmsb;

  // Operands are shifted right each RUN cycle, so the adder always sees bit 0.
  addsub_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    sign_d   = sign_q;
    busy_d   = busy_q;
    done_d   = done_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = (bus.ALUFun0 == ALU_SUB) ? ~bus.B : bus.B;
          carry_d = bus.ALUFun0;
          sub_d   = bus.ALUFun0;
          sign_d  = bus.Sign;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> SLICE_W;
        b_d      = b_q >> SLICE_W;
        carry_d  = slice_cout;
        shadow_d = {slice_sum, shadow_q[WIDTH-1:SLICE_W]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NSLICE - 1)) begin
          s_d     = shadow_d;
          zero_d  = (shadow_d == '0);
          if (sign_q) begin
            ovf_d = slice_cmsb ^ slice_cout;
            neg_d = shadow_d[WIDTH-1];
          end else begin
            ovf_d = (sub_q == ALU_ADD) ? slice_cout : 1'b0;
            neg_d = (sub_q == ALU_SUB) ? ~slice_cout : 1'b0;
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      s_q      <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;
  assign bus.S        = s_q;
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
  assign bus.Negative = neg_q;
endmodule

// File: tb/tb_addsub_seq.sv
// Randomized and directed checks of addsub_seq against an arithmetic model.
module tb_addsub_seq;
  localparam int W = 32;
  localparam int NSL = 4;

  logic clk;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  addsub_seq_if #(.WIDTH(W)) bus ();

  addsub_seq #(.WIDTH(W), .SLICE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {S, Zero, Overflow, Negative} from plain wide arithmetic
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic sign);
    logic [32:0] full;
    logic [31:0] s;
    logic z, o, n;
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    s = full[31:0];
    z = (s == 32'd0);
    if (sign) begin
      n = s[31];
      o = sub ? ((a[31] != b[31]) && (s[31] != a[31]))
              : ((a[31] == b[31]) && (s[31] != a[31]));
    end else if (!sub) begin
      o = full[32];
      n = 1'b0;
    end else begin
      o = 1'b0;
      n = (a < b);
    end
    return {s, z, o, n};
  endfunction

  function automatic logic [34:0] observed();
    return {bus.S, bus.Zero, bus.Overflow, bus.Negative};
  endfunction

  always @(negedge clk) begin
    if (reset && bus.Busy && bus.Done) begin
      vectors++;
      errors++;
      $display("FAIL busy_done_overlap: Busy=%b Done=%b, required not both high", bus.Busy, bus.Done);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sign, output int lat);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.ALUFun0 = sub; bus.Sign = sign; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.Busy, bus.Done, observed()} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {bus.Busy, bus.Done, observed()});
    end
    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: Busy/Done=%b, required 00", {bus.Busy, bus.Done});
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub, sign;
    logic [34:0] exp;
  } dvec_t;

  task automatic test_directed();
    dvec_t tbl[7];
    int lat;
    tbl[0] = '{32'h7FFFFFFF, 32'd1,        1'b0, 1'b1, {32'h80000000, 1'b0, 1'b1, 1'b1}};
    tbl[1] = '{32'd5,        32'd5,        1'b1, 1'b1, {32'h00000000, 1'b1, 1'b0, 1'b0}};
    tbl[2] = '{32'hFFFFFFFD, 32'd2,        1'b1, 1'b1, {32'hFFFFFFFB, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{32'd1,        32'd2,        1'b1, 1'b0, {32'hFFFFFFFF, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, {32'hFFFFFFFE, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{32'h00FFFFFF, 32'd1,        1'b0, 1'b0, {32'h01000000, 1'b0, 1'b0, 1'b0}};
    tbl[6] = '{32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, {32'h00000000, 1'b1, 1'b1, 1'b0}};
    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].sign, lat);
      vectors++;
      if (lat !== NSL) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, required %0d", i, lat, NSL);
      end
      vectors++;
      if (observed() !== tbl[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got S=%h ZON=%b, required S=%h ZON=%b",
                 i, bus.S, observed() & 3'b111, tbl[i].exp[34:3], tbl[i].exp[2:0]);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b;
    logic sub, sign;
    logic [34:0] exp;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = pick_operand();
      b = pick_operand();
      sub = $urandom_range(0, 1);
      sign = $urandom_range(0, 1);
      exp = model(a, b, sub, sign);
      issue(a, b, sub, sign, lat);
      vectors++;
      if (lat !== NSL || observed() !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h sub=%b sign=%b: got lat=%0d S=%h ZON=%b, required lat=%0d S=%h ZON=%b",
                 i, a, b, sub, sign, lat, bus.S, {bus.Zero, bus.Overflow, bus.Negative},
                 NSL, exp[34:3], exp[2:0]);
      end
    end
  endtask

  task automatic test_start_during_run();
    logic [34:0] exp, got;
    int dones, lat;
    exp = model(32'h12345678, 32'h11111111, 1'b0, 1'b0);
    @(negedge clk);
    bus.A = 32'h12345678; bus.B = 32'h11111111; bus.ALUFun0 = 1'b0; bus.Sign = 1'b0;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    @(posedge clk);
    #1;
    bus.Start = 1'b1; bus.A = 32'hFFFFFFFF; bus.B = 32'h00000003; bus.ALUFun0 = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    dones = 0;
    lat = -1;
    got = '0;
    for (int k = 3; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        dones++;
        if (dones == 1) begin
          lat = k;
          got = observed();
        end
      end
    end
    vectors++;
    if (dones !== 1 || lat !== NSL) begin
      errors++;
      $display("FAIL start_in_run_done_count: got %0d Done at edge %0d, required 1 at edge %0d", dones, lat, NSL);
    end
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL start_in_run_result: got %h, required %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [34:0] exp1, exp2;
    int lat;
    bit held;
    exp1 = model(32'h40000000, 32'h40000000, 1'b0, 1'b1);
    exp2 = model(32'h00000064, 32'h000000C8, 1'b1, 1'b1);
    issue(32'h40000000, 32'h40000000, 1'b0, 1'b1, lat);
    vectors++;
    if (lat !== NSL || observed() !== exp1) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d %h, required lat=%0d %h", lat, observed(), NSL, exp1);
    end
    bus.A = 32'h00000064; bus.B = 32'h000000C8; bus.ALUFun0 = 1'b1; bus.Sign = 1'b1;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    vectors++;
    if ({bus.Busy, bus.Done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept: Busy/Done=%b, required 10", {bus.Busy, bus.Done});
    end
    lat = -1;
    held = 1'b1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.Done) begin
        lat = k;
        break;
      end
      if (observed() !== exp1) held = 1'b0;
    end
    vectors++;
    if (!held) begin
      errors++;
      $display("FAIL b2b_hold: outputs changed during RUN, required %h held", exp1);
    end
    vectors++;
    if (lat !== NSL + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles between Done, required %0d", lat, NSL + 1);
    end
    vectors++;
    if (observed() !== exp2) begin
      errors++;
      $display("FAIL b2b_second: got %h, required %h", observed(), exp2);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [34:0] exp;
    int lat;
    bit stray;
    @(negedge clk);
    bus.A = 32'hDEADBEEF; bus.B = 32'd1; bus.ALUFun0 = 1'b0; bus.Sign = 1'b0;
    bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.Busy, bus.Done, observed()} !== 37'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h, required 0", {bus.Busy, bus.Done, observed()});
    end
    @(negedge clk) reset = 1'b1;
    stray = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.Done || bus.Busy) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      errors++;
      $display("FAIL reset_discard: discarded operation produced Busy/Done, required idle");
    end
    exp = {32'd7, 1'b0, 1'b0, 1'b0};
    issue(32'd10, 32'd3, 1'b1, 1'b1, lat);
    vectors++;
    if (lat !== NSL || observed() !== exp) begin
      errors++;
      $display("FAIL post_reset_sub: got lat=%0d %h, required lat=%0d %h", lat, observed(), NSL, exp);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALUFun0 = 1'b0;
    bus.Sign = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle, slice-serial 32-bit ADD/SUB unit for the area-reduced CPU build. It produces the result word and the `Zero`/`Overflow`/`Negative` flag set consumed by the pipeline comparator. Operands are processed one `SLICE_W`-bit slice per clock, least-significant slice first, with a rippled carry register between slices. A `Start`/`Busy`/`Done` handshake connects it to the EX-stage stall logic.

## Interface
- `WIDTH`, default 32: operand and result width.
- `SLICE_W`, default 8: bits processed per cycle. Must divide `WIDTH`. `NSLICE = WIDTH/SLICE_W`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Start` input 1: request. Accepted only in IDLE or DONE.
- `A` input WIDTH: operand A, captured on accept.
- `B` input WIDTH: operand B, captured on accept.
- `ALUFun0` input 1: 0 = ADD, 1 = SUB (A-B). Captured on accept.
- `Sign` input 1: 1 = signed flag semantics, 0 = unsigned. Captured on accept.
- `Busy` output 1: high while slices are being computed.
- `Done` output 1: one-cycle pulse; result and flags valid.
- `S` output WIDTH: result.
- `Zero` output 1: flag.
- `Overflow` output 1: flag.
- `Negative` output 1: flag.

## Operation
- States:
  - IDLE: after reset.
  - RUN: slice counter `cnt` runs 0..NSLICE-1.
  - DONE: one cycle only.
- IDLE/DONE with `Start`=1: capture A, B (B inverted when SUB), ALUFun0, Sign. Carry-in = ALUFun0. Set `cnt`=0 and go to RUN.
- IDLE/DONE with `Start`=0: go to IDLE. In DONE this ends the `Done` pulse.
- RUN, each cycle:
  - Add slice `cnt` of A and B' plus the carry register.
  - Write the sum slice into `S[cnt*SLICE_W +: SLICE_W]` and update the carry register.
  - On `cnt`=NSLICE-1, compute the flags and go to DONE.
- `Start` while in RUN is ignored. The operand registers do not change.
- Flags are computed from the full result and the final carry `c_out`:
  - `Zero` = (S == 0).
  - `Sign`=1: `Overflow` = signed overflow, i.e. carry into the MSB XOR `c_out`. `Negative` = S[WIDTH-1].
  - `Sign`=0, ADD: `Overflow` = `c_out`, `Negative` = 0.
  - `Sign`=0, SUB: `Overflow` = 0, `Negative` = ~`c_out` (borrow).
  - With these rules the comparator's LT test (Overflow XOR Negative) is correct in both modes.
- S and all flags hold their values from DONE until the next accepted request completes. They do not update mid-RUN; S is written slice-wise into a shadow register and transferred to the output in DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE.
  - `Busy`, `Done`, `S`, `Zero`, `Overflow`, `Negative` all go to 0.
  - The in-flight operation is discarded.

## Timing
- Start is accepted on rising edge E0.
- `Busy`=1 from after E0 until after E(NSLICE), which is the last RUN edge.
- `Done`=1 and outputs valid for the cycle after E(NSLICE). Latency = NSLICE+1 edges from accept to the end of `Done`. With defaults, `Done` is visible 4 edges after E0.
- Back-to-back: `Start`=1 during DONE is accepted on the same edge that drops `Done`. Sustained throughput is one result per NSLICE+1 cycles.
- `Busy` and `Done` are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared header/package `alu_defs`:
  - `ALU_ADD`=1'b0, `ALU_SUB`=1'b1.
  - Default `WIDTH`.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The comparator ALUFun[3:1] codes, so this unit and the comparator share one definition.
- One sub-module: `addsub_slice`, a combinational `SLICE_W`-bit adder with ports `a`, `b`, `cin`, `sum`, `cout`, `cmsb` (carry into the slice MSB, needed for signed overflow). It is instantiated once and reused every RUN cycle.

## Test plan
- ADD, Sign=1: A=0x7FFFFFFF, B=1 -> after 4 edges `Done`=1, S=0x80000000, Overflow=1, Negative=1, Zero=0.
- SUB, Sign=1: A=5, B=5 -> S=0, Zero=1, Overflow=0, Negative=0. Next, A=-3, B=2 -> S=0xFFFFFFFB, Negative=1, Overflow=0.
- SUB, Sign=0: A=1, B=2 -> S=0xFFFFFFFF, Negative=1 (borrow), Overflow=0. Then A=0xFFFFFFFF, B=1 -> Negative=0.
- Carry ripple across all slices: ADD A=0x00FFFFFF, B=1 -> S=0x01000000. Also ADD, Sign=0, A=0xFFFFFFFF, B=1 -> S=0, Zero=1, Overflow=1.
- Handshake:
  - `Start` pulsed at cnt=1 of RUN -> ignored; the first result is unchanged and exactly one `Done` is produced.
  - `Start` held during DONE -> second operation accepted with no IDLE cycle; `Done` pulses 5 cycles apart.
- Reset asserted at cnt=2 -> immediately Busy=Done=S=flags=0 and state IDLE. After release, a new SUB 10-3 gives S=7 with normal latency.
